// File: rtl/stage2_id_ex_hazard_reg_pkg.sv
// Shared definitions for the stage 2 -> stage 3 pipeline register and its hazard logic.
// Field widths, branch/jump encodings and the all-zero bubble encoding live here.
package stage2_id_ex_hazard_reg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 5;
    localparam int BJ_W       = 4;

    typedef enum logic [BJ_W-1:0] {
        BJ_NONE = 4'd0,
        BJ_BEQ  = 4'd1,
        BJ_BNE  = 4'd2,
        BJ_BLT  = 4'd3,
        BJ_BGE  = 4'd4,
        BJ_BLTU = 4'd5,
        BJ_BGEU = 4'd6,
        BJ_JAL  = 4'd7,
        BJ_JALR = 4'd8
    } branch_jump_e;

    typedef struct packed {
        logic               regwrite_en;
        logic               mem_read;
        logic               mem_write;
        logic [ALUOP_W-1:0] aluop;
        logic               op1_sel;
        logic               op2_sel;
        logic [BJ_W-1:0]    branch_jump;
    } ex_ctrl_t;

    // Stage 3 forwarding has no x0 guard, so a bubble must carry a zero write address.
    localparam ex_ctrl_t                BUBBLE_CTRL       = '0;
    localparam logic [REG_ADDR_W-1:0]   BUBBLE_WRITE_ADDR = '0;

    function automatic ex_ctrl_t gate_ctrl(input logic valid, input ex_ctrl_t ctrl);
        return valid ? ctrl : BUBBLE_CTRL;
    endfunction

endpackage

// File: rtl/stage2_load_use_detect.sv
// Combinational load-use hazard term: a load in EX whose destination is read by the ID instruction.
// A flush in the same cycle suppresses the stall because the ID instruction is being discarded.
module stage2_load_use_detect
    import stage2_id_ex_hazard_reg_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_regwrite_en,
    input  logic [REG_ADDR_W-1:0] ex_write_addr,
    input  logic                  id_valid,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_addr1,
    input  logic [REG_ADDR_W-1:0] id_addr2,
    input  logic                  flush,
    output logic                  lu_stall
);

    logic hit;
    logic ex_is_load;

    assign hit = (id_uses_rs1 && (id_addr1 == ex_write_addr)) ||
                 (id_uses_rs2 && (id_addr2 == ex_write_addr));

    assign ex_is_load = ex_valid && ex_mem_read && ex_regwrite_en &&
                        (ex_write_addr != '0);

    assign lu_stall = ex_is_load && id_valid && hit && !flush;

endmodule

// File: rtl/stage2_id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, memory-busy hold
// and a saturating count of upstream stall cycles.
module stage2_id_ex_hazard_reg
    import stage2_id_ex_hazard_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ID_VALID,
    input  logic [DATA_WIDTH-1:0] ID_PC,
    input  logic [DATA_WIDTH-1:0] ID_DATA1,
    input  logic [DATA_WIDTH-1:0] ID_DATA2,
    input  logic [DATA_WIDTH-1:0] ID_IMM,
    input  logic [REG_ADDR_W-1:0] ID_ADDR1,
    input  logic [REG_ADDR_W-1:0] ID_ADDR2,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic [REG_ADDR_W-1:0] ID_WRITE_ADDR,
    input  logic                  ID_REGWRITE_EN,
    input  logic                  ID_MEM_READ,
    input  logic                  ID_MEM_WRITE,
    input  logic [ALUOP_W-1:0]    ID_ALUOP,
    input  logic                  ID_OP1_SEL,
    input  logic                  ID_OP2_SEL,
    input  logic [BJ_W-1:0]       ID_BRANCH_JUMP,
    input  logic                  FLUSH,
    input  logic                  MEM_BUSY,
    output logic                  EX_VALID,
    output logic [DATA_WIDTH-1:0] EX_PC,
    output logic [DATA_WIDTH-1:0] EX_DATA1,
    output logic [DATA_WIDTH-1:0] EX_DATA2,
    output logic [DATA_WIDTH-1:0] EX_IMM,
    output logic [REG_ADDR_W-1:0] EX_ADDR1,
    output logic [REG_ADDR_W-1:0] EX_ADDR2,
    output logic [REG_ADDR_W-1:0] EX_WRITE_ADDR,
    output logic                  EX_REGWRITE_EN,
    output logic                  EX_MEM_READ,
    output logic                  EX_MEM_WRITE,
    output logic [ALUOP_W-1:0]    EX_ALUOP,
    output logic                  EX_OP1_SEL,
    output logic                  EX_OP2_SEL,
    output logic [BJ_W-1:0]       EX_BRANCH_JUMP,
    output logic                  LU_STALL,
    output logic                  STALL_UPSTREAM,
    output logic [CNT_WIDTH-1:0]  STALL_COUNT
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] data1_q;
    logic [DATA_WIDTH-1:0] data2_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [REG_ADDR_W-1:0] addr1_q;
    logic [REG_ADDR_W-1:0] addr2_q;
    logic [REG_ADDR_W-1:0] write_addr_q;
    ex_ctrl_t              ctrl_q;
    logic [CNT_WIDTH-1:0]  count_q;

    ex_ctrl_t id_ctrl;
    logic     lu_stall;
    logic     bubble;

    assign id_ctrl = '{
        regwrite_en: ID_REGWRITE_EN,
        mem_read:    ID_MEM_READ,
        mem_write:   ID_MEM_WRITE,
        aluop:       ID_ALUOP,
        op1_sel:     ID_OP1_SEL,
        op2_sel:     ID_OP2_SEL,
        branch_jump: ID_BRANCH_JUMP
    };

    stage2_load_use_detect u_load_use_detect (
        .ex_valid       (valid_q),
        .ex_mem_read    (ctrl_q.mem_read),
        .ex_regwrite_en (ctrl_q.regwrite_en),
        .ex_write_addr  (write_addr_q),
        .id_valid       (ID_VALID),
        .id_uses_rs1    (ID_USES_RS1),
        .id_uses_rs2    (ID_USES_RS2),
        .id_addr1       (ID_ADDR1),
        .id_addr2       (ID_ADDR2),
        .flush          (FLUSH),
        .lu_stall       (lu_stall)
    );

    assign bubble         = FLUSH || lu_stall;
    assign LU_STALL       = lu_stall;
    assign STALL_UPSTREAM = MEM_BUSY || lu_stall;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            imm_q        <= '0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            write_addr_q <= BUBBLE_WRITE_ADDR;
            ctrl_q       <= BUBBLE_CTRL;
            count_q      <= '0;
        end else begin
            if (STALL_UPSTREAM && (count_q != '1)) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
            // A busy memory freezes stage 3 entirely; flush and load-use wait until it clears.
            if (!MEM_BUSY) begin
                if (bubble) begin
                    valid_q      <= 1'b0;
                    pc_q         <= '0;
                    data1_q      <= '0;
                    data2_q      <= '0;
                    imm_q        <= '0;
                    addr1_q      <= '0;
                    addr2_q      <= '0;
                    write_addr_q <= BUBBLE_WRITE_ADDR;
                    ctrl_q       <= BUBBLE_CTRL;
                end else begin
                    valid_q      <= ID_VALID;
                    pc_q         <= ID_PC;
                    data1_q      <= ID_DATA1;
                    data2_q      <= ID_DATA2;
                    imm_q        <= ID_IMM;
                    addr1_q      <= ID_ADDR1;
                    addr2_q      <= ID_ADDR2;
                    write_addr_q <= ID_WRITE_ADDR;
                    ctrl_q       <= gate_ctrl(ID_VALID, id_ctrl);
                end
            end
        end
    end

    assign EX_VALID       = valid_q;
    assign EX_PC          = pc_q;
    assign EX_DATA1       = data1_q;
    assign EX_DATA2       = data2_q;
    assign EX_IMM         = imm_q;
    assign EX_ADDR1       = addr1_q;
    assign EX_ADDR2       = addr2_q;
    assign EX_WRITE_ADDR  = write_addr_q;
    assign EX_REGWRITE_EN = ctrl_q.regwrite_en;
    assign EX_MEM_READ    = ctrl_q.mem_read;
    assign EX_MEM_WRITE   = ctrl_q.mem_write;
    assign EX_ALUOP       = ctrl_q.aluop;
    assign EX_OP1_SEL     = ctrl_q.op1_sel;
    assign EX_OP2_SEL     = ctrl_q.op2_sel;
    assign EX_BRANCH_JUMP = ctrl_q.branch_jump;
    assign STALL_COUNT    = count_q;

endmodule

// File: tb/tb_stage2_id_ex_hazard_reg.sv
// Directed bench for stage2_id_ex_hazard_reg: a vector table for per-edge behaviour,
// then hand-written sequences for asynchronous reset and counter saturation.
module tb_stage2_id_ex_hazard_reg;

    localparam logic [31:0] DKEY = 32'hA5A5_0000;

    typedef struct {
        int v, pc, a1, a2, u1, u2, wa, rw, mr, alu, bj, flush, busy;
        int lu, su, ev, epc, ea1, ewa, erw, emr, ealu, ebj, ecnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_data1, id_data2, id_imm;
    logic [4:0]  id_addr1, id_addr2, id_write_addr, id_aluop;
    logic        id_uses_rs1, id_uses_rs2;
    logic        id_regwrite_en, id_mem_read, id_mem_write, id_op1_sel, id_op2_sel;
    logic [3:0]  id_branch_jump;
    logic        flush, mem_busy;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_data1, ex_data2, ex_imm;
    logic [4:0]  ex_addr1, ex_addr2, ex_write_addr, ex_aluop;
    logic        ex_regwrite_en, ex_mem_read, ex_mem_write, ex_op1_sel, ex_op2_sel;
    logic [3:0]  ex_branch_jump;
    logic        lu_stall, stall_upstream;
    logic [15:0] stall_count;

    int compared;
    int mismatched;
    vec_t vecs[18];

    stage2_id_ex_hazard_reg #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .CLK(clk), .RESET(rst_n),
        .ID_VALID(id_valid), .ID_PC(id_pc), .ID_DATA1(id_data1), .ID_DATA2(id_data2),
        .ID_IMM(id_imm), .ID_ADDR1(id_addr1), .ID_ADDR2(id_addr2),
        .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
        .ID_WRITE_ADDR(id_write_addr), .ID_REGWRITE_EN(id_regwrite_en),
        .ID_MEM_READ(id_mem_read), .ID_MEM_WRITE(id_mem_write), .ID_ALUOP(id_aluop),
        .ID_OP1_SEL(id_op1_sel), .ID_OP2_SEL(id_op2_sel), .ID_BRANCH_JUMP(id_branch_jump),
        .FLUSH(flush), .MEM_BUSY(mem_busy),
        .EX_VALID(ex_valid), .EX_PC(ex_pc), .EX_DATA1(ex_data1), .EX_DATA2(ex_data2),
        .EX_IMM(ex_imm), .EX_ADDR1(ex_addr1), .EX_ADDR2(ex_addr2),
        .EX_WRITE_ADDR(ex_write_addr), .EX_REGWRITE_EN(ex_regwrite_en),
        .EX_MEM_READ(ex_mem_read), .EX_MEM_WRITE(ex_mem_write), .EX_ALUOP(ex_aluop),
        .EX_OP1_SEL(ex_op1_sel), .EX_OP2_SEL(ex_op2_sel), .EX_BRANCH_JUMP(ex_branch_jump),
        .LU_STALL(lu_stall), .STALL_UPSTREAM(stall_upstream), .STALL_COUNT(stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Data operands are derived from the PC so a held or loaded value is recognisable.
    task automatic drive(input vec_t v);
        id_valid       = 1'(v.v);
        id_pc          = 32'(v.pc);
        id_data1       = 32'(v.pc) ^ DKEY;
        id_data2       = 32'(v.pc) + 32'h1000;
        id_imm         = 32'(v.pc) - 32'h4;
        id_addr1       = 5'(v.a1);
        id_addr2       = 5'(v.a2);
        id_uses_rs1    = 1'(v.u1);
        id_uses_rs2    = 1'(v.u2);
        id_write_addr  = 5'(v.wa);
        id_regwrite_en = 1'(v.rw);
        id_mem_read    = 1'(v.mr);
        id_aluop       = 5'(v.alu);
        id_branch_jump = 4'(v.bj);
        id_mem_write   = id_branch_jump[0];
        id_op1_sel     = id_branch_jump[1];
        id_op2_sel     = id_branch_jump[2];
        flush          = 1'(v.flush);
        mem_busy       = 1'(v.busy);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_ex_pc"}, ex_pc, 32'd0);
        chk({tag, "_ex_write_addr"}, 32'(ex_write_addr), 32'd0);
        chk({tag, "_ex_regwrite_en"}, 32'(ex_regwrite_en), 32'd0);
        chk({tag, "_ex_mem_read"}, 32'(ex_mem_read), 32'd0);
        chk({tag, "_ex_data1"}, ex_data1, 32'd0);
    endtask

    initial begin
        vec_t v;
        vec_t lw5;
        vec_t use5;
        int exp_cnt;
        bit timed_out;
        compared   = 0;
        mismatched = 0;

        //            v  pc     a1 a2 u1 u2 wa rw mr alu bj fl bz | lu su ev epc    ea1 ewa erw emr ealu ebj cnt
        vecs[0]  = '{1, 'h100, 2, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 1, 'h100, 2, 5, 1, 1, 1, 0, 0};
        vecs[1]  = '{1, 'h104, 5, 7, 1, 1, 6, 1, 0, 2, 0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 0, 0, 1};
        vecs[2]  = '{1, 'h104, 5, 7, 1, 1, 6, 1, 0, 2, 0, 0, 0, 0, 0, 1, 'h104, 5, 6, 1, 0, 2, 0, 1};
        vecs[3]  = '{1, 'h108, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 'h108, 1, 0, 1, 1, 1, 0, 1};
        vecs[4]  = '{1, 'h10c, 0, 0, 1, 1, 7, 1, 0, 2, 0, 0, 0, 0, 0, 1, 'h10c, 0, 7, 1, 0, 2, 0, 1};
        vecs[5]  = '{1, 'h110, 3, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 1, 'h110, 3, 5, 1, 1, 1, 0, 1};
        vecs[6]  = '{1, 'h114, 4, 5, 1, 0, 8, 1, 0, 3, 0, 0, 0, 0, 0, 1, 'h114, 4, 8, 1, 0, 3, 0, 1};
        vecs[7]  = '{1, 'h118, 4, 0, 1, 0, 5, 1, 0, 2, 0, 0, 0, 0, 0, 1, 'h118, 4, 5, 1, 0, 2, 0, 1};
        vecs[8]  = '{1, 'h11c, 5, 0, 1, 0, 9, 1, 0, 2, 7, 0, 0, 0, 0, 1, 'h11c, 5, 9, 1, 0, 2, 7, 1};
        vecs[9]  = '{0, 'h120, 6, 0, 1, 0, 0, 1, 1, 7, 3, 0, 0, 0, 0, 0, 'h120, 6, 0, 0, 0, 0, 0, 1};
        vecs[10] = '{1, 'h124, 1, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 1, 'h124, 1, 5, 1, 1, 1, 0, 1};
        vecs[11] = '{1, 'h128, 5, 0, 1, 0, 6, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1};
        vecs[12] = '{1, 'h130, 1, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 1, 'h130, 1, 5, 1, 1, 1, 0, 1};
        vecs[13] = '{1, 'h134, 5, 0, 1, 0, 6, 1, 0, 2, 0, 1, 1, 0, 1, 1, 'h130, 1, 5, 1, 1, 1, 0, 2};
        vecs[14] = '{1, 'h134, 5, 0, 1, 0, 6, 1, 0, 2, 0, 1, 1, 0, 1, 1, 'h130, 1, 5, 1, 1, 1, 0, 3};
        vecs[15] = '{1, 'h134, 5, 0, 1, 0, 6, 1, 0, 2, 0, 1, 1, 0, 1, 1, 'h130, 1, 5, 1, 1, 1, 0, 4};
        vecs[16] = '{1, 'h134, 5, 0, 1, 0, 6, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 4};
        vecs[17] = '{1, 'h134, 5, 0, 1, 0, 6, 1, 0, 2, 0, 0, 0, 0, 0, 1, 'h134, 5, 6, 1, 0, 2, 0, 4};

        lw5  = '{1, 'h140, 1, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        use5 = '{1, 'h144, 5, 7, 1, 1, 6, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Clock/reset
        rst_n = 1'b0;
        v = '{default: 0};
        drive(v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_bubble("reset");
        chk("reset_stall_count", 32'(stall_count), 32'd0);
        rst_n = 1'b1;

        // Table: inputs applied on the falling edge, combinational terms checked
        // before the rising edge, registered fields checked just after it.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_lu_stall", i), 32'(lu_stall), 32'(vecs[i].lu));
            chk($sformatf("v%0d_stall_upstream", i), 32'(stall_upstream), 32'(vecs[i].su));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d_ex_pc", i), ex_pc, 32'(vecs[i].epc));
            chk($sformatf("v%0d_ex_data1", i), ex_data1,
                (vecs[i].epc == 0) ? 32'd0 : (32'(vecs[i].epc) ^ DKEY));
            chk($sformatf("v%0d_ex_addr1", i), 32'(ex_addr1), 32'(vecs[i].ea1));
            chk($sformatf("v%0d_ex_write_addr", i), 32'(ex_write_addr), 32'(vecs[i].ewa));
            chk($sformatf("v%0d_ex_regwrite_en", i), 32'(ex_regwrite_en), 32'(vecs[i].erw));
            chk($sformatf("v%0d_ex_mem_read", i), 32'(ex_mem_read), 32'(vecs[i].emr));
            chk($sformatf("v%0d_ex_aluop", i), 32'(ex_aluop), 32'(vecs[i].ealu));
            chk($sformatf("v%0d_ex_branch_jump", i), 32'(ex_branch_jump), 32'(vecs[i].ebj));
            chk($sformatf("v%0d_ex_side_ctrl", i),
                32'({ex_op2_sel, ex_op1_sel, ex_mem_write}), 32'(vecs[i].ebj & 7));
            chk($sformatf("v%0d_stall_count", i), 32'(stall_count), 32'(vecs[i].ecnt));
        end

        // Reset asserted while a load-use stall is pending clears everything at once.
        @(negedge clk);
        drive(lw5);
        @(negedge clk);
        drive(use5);
        #1;
        chk("midstall_ex_regwrite_before", 32'(ex_regwrite_en), 32'd1);
        chk("midstall_lu_stall_before", 32'(lu_stall), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_bubble("midstall");
        chk("midstall_stall_count", 32'(stall_count), 32'd0);
        chk("midstall_lu_stall_after", 32'(lu_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = use5;
        v.pc = 'h200;
        drive(v);
        @(posedge clk);
        #1;
        chk("post_reset_ex_valid", 32'(ex_valid), 32'd1);
        chk("post_reset_ex_pc", ex_pc, 32'h200);
        chk("post_reset_stall_count", 32'(stall_count), 32'd0);

        // Saturation: a long memory-busy hold walks the counter up to 0xFFFE, then three more.
        @(negedge clk);
        mem_busy = 1'b1;
        exp_cnt  = 0;
        timed_out = 1'b0;
        while (exp_cnt < 'hFFFE) begin
            @(posedge clk);
            exp_cnt++;
        end
        #1;
        chk("sat_preload", 32'(stall_count), 32'hFFFE);
        chk("sat_hold_ex_pc", ex_pc, 32'h200);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat_edge%0d", k), 32'(stall_count), 32'hFFFF);
        end
        @(negedge clk);
        mem_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_after_release", 32'(stall_count), 32'hFFFF);
        if (timed_out) chk("sat_timeout", 32'd1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stage2_id_ex_hazard_reg.md
Name: stage2_id_ex_hazard_reg

Overview:
- ID/EX pipeline register sitting directly upstream of the stage 3 operand-forwarding logic.
- Captures decoded operands and control from stage 2 and presents them to stage 3.
- Detects load-use hazards, which forwarding cannot cover, and inserts a bubble while stalling IF/ID.
- Applies branch/jump flushes and memory-busy holds, and keeps a saturating stall-cycle counter.

Parameters:
DATA_WIDTH, 32, width of PC, operand and immediate fields
CNT_WIDTH, 16, width of the stall-cycle counter

Ports:
CLK  input  1  pipeline clock, rising edge
RESET  input  1  asynchronous, active-low reset (0 = reset)
ID_VALID  input  1  stage 2 holds a real instruction
ID_PC  input  DATA_WIDTH  PC of the stage 2 instruction
ID_DATA1, ID_DATA2  input  DATA_WIDTH  register file read data
ID_IMM  input  DATA_WIDTH  decoded immediate
ID_ADDR1, ID_ADDR2  input  5  source register addresses
ID_USES_RS1, ID_USES_RS2  input  1  instruction actually reads rs1/rs2
ID_WRITE_ADDR  input  5  destination register
ID_REGWRITE_EN, ID_MEM_READ, ID_MEM_WRITE  input  1  control
ID_ALUOP  input  5  ALU operation
ID_OP1_SEL, ID_OP2_SEL  input  1  operand source selects
ID_BRANCH_JUMP  input  4  branch/jump type (0 = none)
FLUSH  input  1  taken branch/jump resolved in stage 3
MEM_BUSY  input  1  stage 4 data memory not ready
EX_VALID, EX_PC, EX_DATA1, EX_DATA2, EX_IMM, EX_ADDR1, EX_ADDR2, EX_WRITE_ADDR, EX_REGWRITE_EN, EX_MEM_READ, EX_MEM_WRITE, EX_ALUOP, EX_OP1_SEL, EX_OP2_SEL, EX_BRANCH_JUMP  output  same widths as ID_ counterparts  registered stage 3 fields
LU_STALL  output  1  combinational load-use hazard indication
STALL_UPSTREAM  output  1  combinational; = MEM_BUSY | LU_STALL; holds PC and IF/ID
STALL_COUNT  output  CNT_WIDTH  saturating count of cycles with STALL_UPSTREAM = 1

Behaviour:
- Reset (RESET = 0, asynchronous): every EX_ output and STALL_COUNT is 0. The register therefore holds a bubble.
- Hazard term: LU_STALL = EX_VALID & EX_MEM_READ & EX_REGWRITE_EN & (EX_WRITE_ADDR != 0) & ID_VALID & hit & !FLUSH.
  - hit = (ID_USES_RS1 & ID_ADDR1 == EX_WRITE_ADDR) | (ID_USES_RS2 & ID_ADDR2 == EX_WRITE_ADDR).
- Per rising edge, first matching rule wins:
  - MEM_BUSY = 1: hold all EX_ fields unchanged. FLUSH and load-use are not acted on. The stage 3 source keeps FLUSH stable while MEM_BUSY = 1.
  - FLUSH = 1: load a bubble.
  - LU_STALL = 1: load a bubble. The ID instruction stays in IF/ID via STALL_UPSTREAM and is re-evaluated next cycle.
  - Otherwise: load all ID_ fields, with EX_VALID = ID_VALID.
- Bubble encoding: all EX_ fields 0, giving REGWRITE/MEM/BRANCH all 0 and WRITE_ADDR 0. Stage 3 forwarding compares addresses without an x0 check, so this zero encoding is mandatory.
- If ID_VALID = 0 on a normal load: control fields are loaded as 0 regardless of ID_ control inputs.
- Load-use penalty: exactly 1 bubble. On the next cycle the load is in stage 4 and stage 3 forwards from it.
- STALL_COUNT: +1 on each edge with STALL_UPSTREAM = 1. It saturates at all-ones and never wraps.
- Reset asserted mid-stall: immediate bubble and counter cleared. After release, normal load resumes on the first edge.

Decomposition:
- Shared package holds:
  - bubble control constants;
  - BRANCH_JUMP encodings (0 = none);
  - ALUOP width;
  - register-address width 5.
- One sub-module: stage2_load_use_detect, the combinational hit/LU_STALL term, reusable by a later hazard unit.
- The register bank and counter stay in the top block.

Test Plan:
- Reset: RESET = 0 mid-run with EX_REGWRITE_EN = 1 -> all EX_ = 0 and STALL_COUNT = 0 without waiting for an edge.
- Load-use: EX holds lw x5 (MEM_READ = 1, WRITE_ADDR = 5); ID holds add x6,x5,x7 -> LU_STALL = 1, next edge EX_VALID = 0 and EX_WRITE_ADDR = 0. Following edge EX_ADDR1 = 5 and LU_STALL = 0; STALL_COUNT = 1.
- No false hazard:
  - lw x0 followed by a use of x0 -> LU_STALL = 0.
  - lw x5 followed by an instruction with ID_USES_RS2 = 0 and ID_ADDR2 = 5 -> LU_STALL = 0.
  - add x5 (MEM_READ = 0) followed by a use of x5 -> LU_STALL = 0.
- Flush priority: FLUSH = 1 together with a load-use hit -> LU_STALL = 0, STALL_UPSTREAM = 0, next edge bubble.
- Memory hold: MEM_BUSY = 1 for 3 cycles with FLUSH = 1 -> EX_ unchanged for 3 edges and STALL_COUNT += 3. Bubble on the first edge after MEM_BUSY = 0.
- Saturation: preload count path to 0xFFFE, stall 3 cycles -> STALL_COUNT = 0xFFFF and stays there.
